// File: rtl/gpio_sched_pkg.sv
// Shared types and constants for the GPIO TX scheduler and its shifter wrapper.
package gpio_sched_pkg;

  localparam int unsigned DEF_NREQ = 4;
  localparam int unsigned DEF_DW   = 8;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_LOAD = 2'd1,
    ST_WAIT = 2'd2,
    ST_TURN = 2'd3
  } sched_state_e;

  // Index width for n items; never below one bit.
  function automatic int unsigned idx_w(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/gpio_rr_arbiter.sv
// Combinational round-robin picker: first valid requester after last_grant, wrapping.
module gpio_rr_arbiter
  import gpio_sched_pkg::*;
#(
  parameter int unsigned NREQ = DEF_NREQ,
  localparam int unsigned IW  = idx_w(NREQ)
) (
  input  logic [NREQ-1:0] req_valid_i,
  input  logic [IW-1:0]   last_grant_i,
  output logic [NREQ-1:0] winner_oh_o,
  output logic [IW-1:0]   winner_idx_o,
  output logic            any_valid_o
);

  always_comb begin
    int unsigned cand;
    logic        found;
    cand         = 0;
    found        = 1'b0;
    winner_oh_o  = '0;
    winner_idx_o = '0;
    for (int unsigned k = 1; k <= NREQ; k++) begin
      cand = 32'(last_grant_i) + k;
      if (cand >= NREQ) cand = cand - NREQ;
      if (!found && req_valid_i[IW'(cand)]) begin
        found                    = 1'b1;
        winner_oh_o[IW'(cand)]   = 1'b1;
        winner_idx_o             = IW'(cand);
      end
    end
    any_valid_o = found;
  end

endmodule

// File: rtl/gpio_tx_scheduler.sv
// Round-robin scheduler feeding one GPIO TX shifter: accept, load, wait done, guard, release.
// Optional WAIT timeout with sticky err is enabled by GPIO_TX_SCHED_TIMEOUT_EN.
module gpio_tx_scheduler
  import gpio_sched_pkg::*;
#(
  parameter int unsigned NREQ     = DEF_NREQ,
  parameter int unsigned DW       = DEF_DW,
  parameter int unsigned TURN_CYC = 2,
  parameter int unsigned TIMEOUT  = 32,
  localparam int unsigned IW      = idx_w(NREQ),
  localparam int unsigned CNT_MAX = (TURN_CYC > TIMEOUT) ? TURN_CYC : TIMEOUT,
  localparam int unsigned CNT_W   = idx_w(CNT_MAX + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [NREQ-1:0]  req_valid,
  input  logic [NREQ*DW-1:0] req_data,
  output logic [NREQ-1:0]  req_ready,
  output logic             sh_load,
  output logic [DW-1:0]    sh_data,
  input  logic             sh_done,
  output logic             gpio_direction,
  output logic [IW-1:0]    grant_id,
  output logic             busy,
  output logic             err
);

  localparam logic [CNT_W-1:0] TURN_LD = CNT_W'(TURN_CYC - 1);

  sched_state_e      state_q, state_d;
  logic [DW-1:0]     data_q, data_d;
  logic [IW-1:0]     grant_q, grant_d;
  logic [IW-1:0]     last_q, last_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              load_q, load_d;
  logic              dir_q, dir_d;
  logic              busy_q, busy_d;

  logic [NREQ-1:0]   win_oh;
  logic [IW-1:0]     win_idx;
  logic              win_any;

  gpio_rr_arbiter #(.NREQ(NREQ)) u_arb (
    .req_valid_i  (req_valid),
    .last_grant_i (last_q),
    .winner_oh_o  (win_oh),
    .winner_idx_o (win_idx),
    .any_valid_o  (win_any)
  );

`ifdef GPIO_TX_SCHED_TIMEOUT_EN
  localparam logic [CNT_W-1:0] TO_LD = CNT_W'(TIMEOUT - 1);
  logic err_q, err_d;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      data_q  <= '0;
      grant_q <= '0;
      last_q  <= IW'(NREQ - 1);
      cnt_q   <= '0;
      load_q  <= 1'b0;
      dir_q   <= 1'b0;
      busy_q  <= 1'b0;
`ifdef GPIO_TX_SCHED_TIMEOUT_EN
      err_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      data_q  <= data_d;
      grant_q <= grant_d;
      last_q  <= last_d;
      cnt_q   <= cnt_d;
      load_q  <= load_d;
      dir_q   <= dir_d;
      busy_q  <= busy_d;
`ifdef GPIO_TX_SCHED_TIMEOUT_EN
      err_q   <= err_d;
`endif
    end
  end

  // Next state; outputs are registered decodes of the next state.
  always_comb begin
    state_d = state_q;
    data_d  = data_q;
    grant_d = grant_q;
    last_d  = last_q;
    cnt_d   = cnt_q;
`ifdef GPIO_TX_SCHED_TIMEOUT_EN
    err_d   = err_q;
`endif
    unique case (state_q)
      ST_IDLE: begin
        if (win_any) begin
          data_d  = req_data[win_idx*DW +: DW];
          grant_d = win_idx;
          last_d  = win_idx;
          state_d = ST_LOAD;
`ifdef GPIO_TX_SCHED_TIMEOUT_EN
          cnt_d   = TO_LD;
`endif
        end
      end
      ST_LOAD: begin
        state_d = ST_WAIT;
`ifdef GPIO_TX_SCHED_TIMEOUT_EN
        cnt_d   = cnt_q - CNT_W'(1);
`endif
      end
      ST_WAIT: begin
        if (sh_done) begin
          if (TURN_CYC == 0) begin
            state_d = ST_IDLE;
          end else begin
            state_d = ST_TURN;
            cnt_d   = TURN_LD;
          end
        end
`ifdef GPIO_TX_SCHED_TIMEOUT_EN
        else if (cnt_q == '0) begin
          err_d   = 1'b1;
          state_d = ST_IDLE;
        end else begin
          cnt_d   = cnt_q - CNT_W'(1);
        end
`endif
      end
      ST_TURN: begin
        if (cnt_q == '0) state_d = ST_IDLE;
        else             cnt_d   = cnt_q - CNT_W'(1);
      end
      default: state_d = ST_IDLE;
    endcase
    load_d = (state_d == ST_LOAD);
    dir_d  = (state_d != ST_IDLE);
    busy_d = (state_d != ST_IDLE);
  end

  // Ready is the only combinational output: the arbiter's pick while idle.
  assign req_ready      = (state_q == ST_IDLE && !rst) ? win_oh : '0;
  assign sh_load        = load_q;
  assign sh_data        = data_q;
  assign gpio_direction = dir_q;
  assign grant_id       = grant_q;
  assign busy           = busy_q;
`ifdef GPIO_TX_SCHED_TIMEOUT_EN
  assign err            = err_q;
`else
  assign err            = 1'b0;
`endif

endmodule
